// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one sequential divider between two requesters.
// Optional WAIT watchdog enabled by defining DIV_WAIT_TIMEOUT_EN.
module div_share_arbiter #(
    parameter int W         = 3,
    parameter int TO_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [W-1:0] A0,
    input  logic [W-1:0] A1,
    input  logic [W-1:0] B0,
    input  logic [W-1:0] B1,
    output logic         ACK0,
    output logic         ACK1,
    output logic [W-1:0] Q,
    output logic         DZ,
    output logic         TO_ERR,
    output logic         BUSY,
    output logic         DIV_START,
    output logic [W-1:0] DIV_A,
    output logic [W-1:0] DIV_B,
    input  logic         DIV_DONE,
    input  logic [W-1:0] DIV_Q
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t       state_q, state_d;
    logic         ack0_q, ack0_d, ack1_q, ack1_d;
    logic         dz_q, dz_d, to_q, to_d;
    logic         start_q, start_d, busy_q, busy_d;
    logic         sel_q, sel_d, pref_q, pref_d;
    logic [W-1:0] q_q, q_d, a_q, a_d, b_q, b_d;
    logic         grant, expired;
    logic [W-1:0] a_sel, b_sel;

    // pref_q names the port that wins when both request at once
    assign grant = (REQ0 && REQ1) ? pref_q : REQ1;
    assign a_sel = grant ? A1 : A0;
    assign b_sel = grant ? B1 : B0;

`ifdef DIV_WAIT_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign expired = cnt_q == CW'(TO_CYCLES);
`else
    assign expired = 1'b0;
    if (TO_CYCLES < 1) begin : g_bad_to_cycles
    end
`endif

    always_comb begin
        state_d = state_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        dz_d    = dz_q;
        to_d    = to_q;
        start_d = start_q;
        sel_d   = sel_q;
        pref_d  = pref_q;
        q_d     = q_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef DIV_WAIT_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    sel_d = grant;
                    a_d   = a_sel;
                    b_d   = b_sel;
                    if (b_sel != '0) begin
                        start_d = 1'b1;
                        state_d = S_WAIT;
`ifdef DIV_WAIT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // divide-by-zero answered locally, divider never started
                        q_d     = '1;
                        dz_d    = 1'b1;
                        to_d    = 1'b0;
                        ack0_d  = ~grant;
                        ack1_d  = grant;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
`ifdef DIV_WAIT_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (DIV_DONE || expired) begin
                    q_d     = DIV_DONE ? DIV_Q : '0;
                    to_d    = ~DIV_DONE;
                    dz_d    = 1'b0;
                    start_d = 1'b0;
                    ack0_d  = ~sel_q;
                    ack1_d  = sel_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                dz_d    = 1'b0;
                to_d    = 1'b0;
                pref_d  = ~sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 1'b0;
            pref_q  <= 1'b0;
            q_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef DIV_WAIT_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            pref_q  <= pref_d;
            q_q     <= q_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef DIV_WAIT_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign ACK0      = ack0_q;
    assign ACK1      = ack1_q;
    assign Q         = q_q;
    assign DZ        = dz_q;
    assign TO_ERR    = to_q;
    assign BUSY      = busy_q;
    assign DIV_START = start_q;
    assign DIV_A     = a_q;
    assign DIV_B     = b_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: scoreboard bench for div_share_arbiter with a behavioural divider and requesters.
module tb_div_share_arbiter;
    localparam int TO = 8;

    logic       clk, rst;
    logic       REQ0, REQ1, ACK0, ACK1, DZ, TO_ERR, BUSY, DIV_START, DIV_DONE;
    logic [2:0] A0, A1, B0, B1, Q, DIV_A, DIV_B, DIV_Q;

    div_share_arbiter #(.W(3), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .REQ0(REQ0), .REQ1(REQ1), .A0(A0), .A1(A1), .B0(B0), .B1(B1),
        .ACK0(ACK0), .ACK1(ACK1), .Q(Q), .DZ(DZ), .TO_ERR(TO_ERR), .BUSY(BUSY),
        .DIV_START(DIV_START), .DIV_A(DIV_A), .DIV_B(DIV_B), .DIV_DONE(DIV_DONE), .DIV_Q(DIV_Q)
    );

    typedef struct {
        int port;
        int q;
        int dz;
        int to;
        int kind;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0, checks = 0;
    int   cyc = 0, issue_cyc = 0, done_cyc = 0;
    int   starts = 0, exp_starts = 0, low_run = 0, lat = 0, dcnt = 0;
    bit   single_mode = 0, lat_long = 0, never_done = 0, started_once = 0;
    bit   prev_start = 0, prev_ack = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // divider model: DONE after a random number of cycles, held until START drops
    always @(negedge clk) begin
        if (!DIV_START) begin
            DIV_DONE = 1'b0;
            dcnt     = 0;
            lat      = $urandom_range(0, 5);
        end else if (!DIV_DONE && !never_done) begin
            if (dcnt >= (lat_long ? 1000 : lat)) begin
                DIV_DONE = 1'b1;
                DIV_Q    = DIV_A / DIV_B;
                done_cyc = cyc;
            end else dcnt++;
        end
    end

    always @(negedge clk) begin
        if (DIV_START && !prev_start) begin
            if (started_once) chk("start_gap_ge2", int'(low_run >= 2), 1);
            if (single_mode) chk("start_latency", cyc, issue_cyc + 1);
            started_once = 1;
            starts++;
            low_run = 0;
        end else if (!DIV_START) low_run++;
        prev_start = DIV_START;
    end

    always @(negedge clk) begin
        if (ACK0 || ACK1) begin
            chk("ack_onehot", int'(ACK0 && ACK1), 0);
            chk("ack_pulse", int'(prev_ack), 0);
            if (sb.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("ack_port", int'(ACK1), mon_e.port);
                chk("q", int'(Q), mon_e.q);
                chk("dz", int'(DZ), mon_e.dz);
                chk("to_err", int'(TO_ERR), mon_e.to);
                if (mon_e.kind == 1) chk("ack_cycle", cyc, mon_e.cyc);
                else if (mon_e.kind == 2) chk("ack_after_done", cyc, done_cyc + 1);
            end
        end
        prev_ack = ACK0 || ACK1;
    end

    task automatic issue(input int p, input int a, input int b, input bit push, input bit dz_lat);
        exp_t e;
        if (p == 0) begin REQ0 = 1'b1; A0 = 3'(a); B0 = 3'(b); end
        else begin REQ1 = 1'b1; A1 = 3'(a); B1 = 3'(b); end
        issue_cyc = cyc;
        if (b != 0) exp_starts++;
        if (push) begin
            e.port = p;
            e.q    = (b == 0) ? 7 : a / b;
            e.dz   = int'(b == 0);
            e.to   = 0;
            e.kind = (b != 0) ? 2 : (dz_lat ? 1 : 0);
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_ack(input int p);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(p == 0 ? ACK0 : ACK1) && n < 200);
        chk("ack_wait_bound", int'(n < 200), 1);
        if (p == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
    endtask

    function automatic int rb();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n, p, pref, issued;
        exp_t e;
        rst = 1; REQ0 = 0; REQ1 = 0; A0 = 0; A1 = 0; B0 = 0; B1 = 0;
        DIV_DONE = 0; DIV_Q = 0;
        repeat (3) @(negedge clk);
        chk("reset_acks", int'({ACK0, ACK1}), 0);
        chk("reset_flags", int'({DZ, TO_ERR, BUSY, DIV_START}), 0);
        chk("reset_data", int'({Q, DIV_A, DIV_B}), 0);
        rst = 0;
        @(negedge clk);
        // contention right after reset: port 0 favoured, then strict alternation
        pref = 0;
        issue(0, 7, 2, 1, 0);
        issue(1, 5, 1, 1, 0);
        issued = 2;
        for (int g = 0; g < 12; g++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!ACK0 && !ACK1 && n < 200);
            chk("grant_wait_bound", int'(n < 200), 1);
            p = ACK1 ? 1 : 0;
            chk("grant_order", p, pref);
            pref = 1 - p;
            if (p == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
            if (issued < 12) begin
                @(negedge clk);
                issue(p, int'($urandom_range(0, 7)), rb(), 1, 0);
                issued++;
            end
        end
        // single requests with latency checks
        @(negedge clk);
        single_mode = 1;
        issue(0, 6, 2, 1, 1); wait_ack(0);
        @(negedge clk);
        issue(1, 4, 0, 1, 1); wait_ack(1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            p = int'($urandom_range(0, 1));
            issue(p, int'($urandom_range(0, 7)), rb(), 1, 1);
            wait_ack(p);
        end
        // reset while waiting on the divider: operation dropped, no ACK
        @(negedge clk);
        single_mode = 0;
        lat_long = 1;
        issue(0, 5, 1, 0, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!DIV_START && n < 20);
        chk("start_before_reset", int'(DIV_START), 1);
        @(negedge clk);
        rst = 1; REQ0 = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        lat_long = 0;
        chk("rst_div_start", int'(DIV_START), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_acks", int'({ACK0, ACK1}), 0);
        @(negedge clk);
        single_mode = 1;
        issue(0, 6, 3, 1, 1); wait_ack(0);
`ifdef DIV_WAIT_TIMEOUT_EN
        // divider never answers: watchdog ends the operation
        @(negedge clk);
        never_done = 1;
        issue(1, 6, 2, 0, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!DIV_START && n < 20);
        e.port = 1; e.q = 0; e.dz = 0; e.to = 1; e.kind = 1; e.cyc = cyc + TO + 1;
        sb.push_back(e);
        wait_ack(1);
        never_done = 0;
`endif
        n = 0;
        while (sb.size() > 0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("div_starts", starts, exp_starts);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
